// File: rtl/iso7816_pkg.sv
// iso7816_pkg: shared state type, constants and bit helpers for the
// ISO 7816-3 character path (transmitter and etu counter).
package iso7816_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    ERRCHK,
    ERRWAIT,
    GUARD
  } txState_t;

  localparam int MIN_CPB     = 3;
  localparam int ERRWAIT_ETU = 2;

  // Data bit for slot idx: LSB first, or MSB first in inverse mode.
  function automatic logic pickBit(
    input logic [7:0] d,
    input logic [2:0] idx,
    input logic       inv
  );
    return inv ? d[3'd7 - idx] : d[idx];
  endfunction

  // Pull-down request for a logical bit (inverse: logic 1 = low).
  function automatic logic lineLow(
    input logic b,
    input logic inv
  );
    return inv ? b : ~b;
  endfunction

endpackage

// File: rtl/iso7816_etu_counter.sv
// iso7816_etu_counter: counts 0..limit, pulses wrap at the bit boundary
// and half at count (limit+1)/2. Shared by the T=0 transmit and receive paths.
module iso7816_etu_counter
  import iso7816_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         wrap,
  output logic         half
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;
  logic [W:0]   sumV;

  assign sumV = {1'b0, limit} + {{W{1'b0}}, 1'b1};
  assign wrap = enable && !load && (count == limit);
  assign half = enable && !load && (count == sumV[W:1]);

  // Free-running etu position; load parks it at zero.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/iso7816_char_tx.sv
// iso7816_char_tx: T=0 character transmitter with error-signal retry.
// Optional ISO7816_INVERSE_CONVENTION_EN adds the inverseConvention input.
module iso7816_char_tx #(
  parameter int CPB_WIDTH   = 13,
  parameter int MAX_RETRIES = 3
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic [7:0]           txData,
  input  logic [CPB_WIDTH-1:0] clocksPerBit,
  input  logic                 stopBit2,
  input  logic                 startTx,
  input  logic                 ackFlags,
  input  logic                 serialIn,
`ifdef ISO7816_INVERSE_CONVENTION_EN
  input  logic                 inverseConvention,
`endif
  output logic                 txDriveLow,
  output logic                 txFull,
  output logic                 isTx,
  output logic                 txDone,
  output logic                 retryErrorFlag,
  output logic [2:0]           retryCount
);

  import iso7816_pkg::*;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRIES);
  localparam logic [2:0] EW_LAST = 3'(ERRWAIT_ETU - 1);
  localparam logic [CPB_WIDTH-1:0] CPB_MIN =
    CPB_WIDTH'(MIN_CPB);

  txState_t             state;
  logic [7:0]           dataHold;
  logic [CPB_WIDTH-1:0] cpbHold;
  logic [CPB_WIDTH-1:0] cpbEff;
  logic [2:0]           bitIdx;
  logic [2:0]           nextIdx;
  logic                 errSeen;
  logic                 giveUp;
  logic                 seenHigh;
  logic                 syncA;
  logic                 syncB;
  logic                 etuLoad;
  logic                 etuEn;
  logic                 etuWrap;
  logic                 etuHalf;
  logic                 invMode;

`ifdef ISO7816_INVERSE_CONVENTION_EN
  logic invHold;
  assign invMode = invHold;
`else
  assign invMode = 1'b0;
`endif

  assign cpbEff  = (clocksPerBit < CPB_MIN) ? CPB_MIN : clocksPerBit;
  assign etuEn   = (state != IDLE);
  assign etuLoad = (state == IDLE) ||
                   (state == ERRWAIT && !seenHigh && !syncB);
  assign nextIdx = bitIdx + 3'd1;

  iso7816_etu_counter #(
    .W(CPB_WIDTH)
  ) uEtu (
    .clk    (clk),
    .nReset (nReset),
    .load   (etuLoad),
    .enable (etuEn),
    .limit  (cpbHold),
    .wrap   (etuWrap),
    .half   (etuHalf)
  );

  // Two-flop synchroniser for the shared line; idles high.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      syncA <= 1'b1;
      syncB <= 1'b1;
    end else begin
      syncA <= serialIn;
      syncB <= syncA;
    end
  end

  // Character FSM with registered line drive and status outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state          <= IDLE;
      dataHold       <= '0;
      cpbHold        <= CPB_MIN;
      bitIdx         <= '0;
      errSeen        <= 1'b0;
      giveUp         <= 1'b0;
      seenHigh       <= 1'b0;
      txDriveLow     <= 1'b0;
      txFull         <= 1'b0;
      isTx           <= 1'b0;
      txDone         <= 1'b0;
      retryErrorFlag <= 1'b0;
      retryCount     <= '0;
`ifdef ISO7816_INVERSE_CONVENTION_EN
      invHold        <= 1'b0;
`endif
    end else begin
      txDone <= 1'b0;
      if (ackFlags) retryErrorFlag <= 1'b0;
      unique case (state)
        IDLE: begin
          if (startTx) begin
            dataHold   <= txData;
            cpbHold    <= cpbEff;
            bitIdx     <= '0;
            retryCount <= '0;
            txFull     <= 1'b1;
            isTx       <= 1'b1;
            txDriveLow <= 1'b1;
            state      <= START;
`ifdef ISO7816_INVERSE_CONVENTION_EN
            invHold    <= inverseConvention;
`endif
          end
        end
        START: begin
          if (etuWrap) begin
            bitIdx     <= '0;
            txDriveLow <= lineLow(
              pickBit(dataHold, 3'd0, invMode), invMode);
            state      <= DATA;
          end
        end
        DATA: begin
          if (etuWrap) begin
            if (bitIdx == 3'd7) begin
              txDriveLow <= lineLow(^dataHold, invMode);
              state      <= PARITY;
            end else begin
              bitIdx     <= nextIdx;
              txDriveLow <= lineLow(
                pickBit(dataHold, nextIdx, invMode), invMode);
            end
          end
        end
        PARITY: begin
          if (etuWrap) begin
            txDriveLow <= 1'b0;
            errSeen    <= 1'b0;
            giveUp     <= 1'b0;
            state      <= ERRCHK;
          end
        end
        ERRCHK: begin
          if (etuHalf && !syncB) begin
            if (retryCount < MAX_R) begin
              retryCount <= retryCount + 3'd1;
              errSeen    <= 1'b1;
            end else begin
              retryErrorFlag <= 1'b1;
              giveUp         <= 1'b1;
            end
          end
          // The error-window etu doubles as the first guard etu.
          if (etuWrap) begin
            bitIdx <= '0;
            if (giveUp) begin
              txFull <= 1'b0;
              isTx   <= 1'b0;
              state  <= IDLE;
            end else if (errSeen) begin
              seenHigh <= 1'b0;
              state    <= ERRWAIT;
            end else if (stopBit2) begin
              state <= GUARD;
            end else begin
              txDone <= 1'b1;
              txFull <= 1'b0;
              isTx   <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        ERRWAIT: begin
          if (!seenHigh && syncB) seenHigh <= 1'b1;
          if (etuWrap) begin
            if (bitIdx == EW_LAST) begin
              bitIdx     <= '0;
              txDriveLow <= 1'b1;
              state      <= START;
            end else begin
              bitIdx <= nextIdx;
            end
          end
        end
        GUARD: begin
          if (etuWrap) begin
            txDone <= 1'b1;
            txFull <= 1'b0;
            isTx   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
